aes_inv_sub_bytes: RTL and testbench

Sequential InvSubBytes engine for the AES decryption datapath. It accepts a 128-bit state over a valid/ready handshake and replaces every byte with its inverse S-box value, processing LANES bytes per cycle. The inverse S-box is computed arithmetically (inverse affine transform, then GF(2^8) multiplicative inverse), so it is the decryption-side counterpart of the forward S-box lookup. It sits between AddRoundKey/InvShiftRows and the decryption round controller.

---
 rtl/aes_inv_sub_bytes_if.sv | 31 +++
 rtl/aes_inv_sub_bytes.sv | 126 ++++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_sub_bytes_if.sv
// Handshake bus for the sequential InvSubBytes engine.
// AES_INV_SUB_BYTES_ABORT_EN adds the i_abort request line.
interface aes_inv_sub_bytes_if;
  localparam int unsigned DW = 128;

  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
`ifdef AES_INV_SUB_BYTES_ABORT_EN
  logic          i_abort;
`endif

  modport slave (
`ifdef AES_INV_SUB_BYTES_ABORT_EN
    input  i_abort,
`endif
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
  );

  modport master (
`ifdef AES_INV_SUB_BYTES_ABORT_EN
    output i_abort,
`endif
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
  );
endinterface

// File: rtl/aes_inv_sub_bytes.sv
// Sequential AES InvSubBytes: LANES bytes per cycle, inverse S-box computed arithmetically.
// Optional AES_INV_SUB_BYTES_ABORT_EN adds an abort request that returns BUSY/DONE to IDLE.
module aes_inv_sub_bytes #(
  parameter int unsigned LANES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  aes_inv_sub_bytes_if.slave bus
);
  localparam int unsigned DW     = 128;
  localparam int unsigned NCHUNK = 16 / LANES;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [7:0]    AFF_C      = 8'h05;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_valid_q, o_valid_d;
  logic          o_ready_q, o_ready_d;
  logic          take;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 via an addition chain; maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ AFF_C[i];
    end
    return r;
  endfunction

`ifdef AES_INV_SUB_BYTES_ABORT_EN
  assign take = (state_q == IDLE) && o_ready_q && bus.i_valid && !bus.i_abort;
`else
  assign take = (state_q == IDLE) && o_ready_q && bus.i_valid;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          data_d  = bus.i_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < int'(LANES); l++) begin
          int k;
          k = int'(cnt_q) * int'(LANES) + l;
          data_d[127 - 8*k -: 8] = gf_inv(inv_affine(data_q[127 - 8*k -: 8]));
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CHUNK) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // i_ready only counts once o_valid is actually presented.
        if (o_valid_q && bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_INV_SUB_BYTES_ABORT_EN
    if (bus.i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end
`endif
    o_valid_d = (state_q == DONE) && (state_d == DONE);
    o_ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_ready_q <= o_ready_d;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_ready = o_ready_q;
  assign bus.o_data  = data_q;
endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Bench for aes_inv_sub_bytes: LANES=1, 4 and 16 instances driven in lockstep against a table model.
module tb_aes_inv_sub_bytes;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [127:0] data = '0;
  logic         rdy = 1'b0;
  logic         abort = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam int LAT [3] = '{17, 5, 2};

  aes_inv_sub_bytes_if b1 ();
  aes_inv_sub_bytes_if b4 ();
  aes_inv_sub_bytes_if b16 ();

  assign b1.i_valid = valid;  assign b4.i_valid = valid;  assign b16.i_valid = valid;
  assign b1.i_data  = data;   assign b4.i_data  = data;   assign b16.i_data  = data;
  assign b1.i_ready = rdy;    assign b4.i_ready = rdy;    assign b16.i_ready = rdy;
`ifdef AES_INV_SUB_BYTES_ABORT_EN
  assign b1.i_abort = abort;  assign b4.i_abort = abort;  assign b16.i_abort = abort;
`endif

  aes_inv_sub_bytes #(.LANES(1))  u_l1  (.i_clk(clk), .i_rst(rst), .bus(b1));
  aes_inv_sub_bytes #(.LANES(4))  u_l4  (.i_clk(clk), .i_rst(rst), .bus(b4));
  aes_inv_sub_bytes #(.LANES(16)) u_l16 (.i_clk(clk), .i_rst(rst), .bus(b16));

  always #5 clk = ~clk;

  wire [2:0] vld  = {b16.o_valid, b4.o_valid, b1.o_valid};
  wire [2:0] ordy = {b16.o_ready, b4.o_ready, b1.o_ready};

  function automatic logic [127:0] dout(input int i);
    case (i)
      0:       return b1.o_data;
      1:       return b4.o_data;
      default: return b16.o_data;
    endcase
  endfunction

  // Reference model: forward S-box built from brute-force inverses, then inverted as a table.
  logic [7:0] fwd [256];
  logic [7:0] rev [256];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic void build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      fwd[x] = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) rev[fwd[x]] = 8'(x);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = rev[v[127 - 8*k -: 8]];
    return r;
  endfunction

  int           lat_obs [3];
  logic [127:0] res_obs [3];
  logic [2:0]   vld_after, rdy_after, rdy_after2;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ordy != 3'b111 && n < 60) begin
      cyc();
      n++;
    end
  endtask

  // Issue one state and record each instance's latency and first valid output.
  task automatic send(input logic [127:0] din);
    int j;
    wait_ready();
    for (int i = 0; i < 3; i++) begin lat_obs[i] = -1; res_obs[i] = 'x; end
    valid = 1'b1;
    data  = din;
    cyc();
    valid = 1'b0;
    j = 0;
    while ((lat_obs[0] < 0 || lat_obs[1] < 0 || lat_obs[2] < 0) && j < 40) begin
      cyc();
      j++;
      for (int i = 0; i < 3; i++)
        if (lat_obs[i] < 0 && vld[i]) begin
          lat_obs[i] = j;
          res_obs[i] = dout(i);
        end
    end
  endtask

  task automatic release_out();
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    vld_after = vld;
    rdy_after = ordy;
    cyc();
    rdy_after2 = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (vld[i] !== 1'b0 || ordy[i] !== 1'b1 || dout(i) !== 128'h0)
        $display("FAIL reset[%0d]: valid=%b ready=%b data=%h, want valid=0 ready=1 data=0",
                 i, vld[i], ordy[i], dout(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_known();
    logic [127:0] exp_v = 128'h000102030405060708090a0b0c0d0e0f;
    send(128'h637c777bf26b6fc53001672bfed7ab76);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (lat_obs[i] !== LAT[i] || res_obs[i] !== exp_v)
        $display("FAIL known[%0d]: lat=%0d data=%h, want lat=%0d data=%h",
                 i, lat_obs[i], res_obs[i], LAT[i], exp_v);
      else pass_cnt++;
    end
    release_out();
    total_cnt++;
    if (vld_after !== 3'b000 || rdy_after !== 3'b000 || rdy_after2 !== 3'b111)
      $display("FAIL known_release: valid=%b ready=%b then ready=%b, want 000 000 111",
               vld_after, rdy_after, rdy_after2);
    else pass_cnt++;
  endtask

  task automatic test_edge();
    logic [127:0] exp_v = {4{32'h52ff4800}};
    send({4{32'h00165263}});
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (lat_obs[i] !== LAT[i] || res_obs[i] !== exp_v)
        $display("FAIL edge[%0d]: lat=%0d data=%h, want lat=%0d data=%h",
                 i, lat_obs[i], res_obs[i], LAT[i], exp_v);
      else pass_cnt++;
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [127:0] din = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] exp_v = model(din);
    logic         bad = 1'b0;
    send(din);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (res_obs[i] !== exp_v)
        $display("FAIL bp_data[%0d]: data=%h, want %h", i, res_obs[i], exp_v);
      else pass_cnt++;
    end
    for (int c = 0; c < 10; c++) begin
      valid = 1'b1;
      data  = ~din;
      cyc();
      for (int i = 0; i < 3; i++)
        if (vld[i] !== 1'b1 || ordy[i] !== 1'b0 || dout(i) !== exp_v) bad = 1'b1;
    end
    valid = 1'b0;
    total_cnt++;
    if (bad) $display("FAIL bp_hold: valid=%b ready=%b during stall, want valid=111 ready=000 stable data", vld, ordy);
    else pass_cnt++;
    release_out();
    total_cnt++;
    if (vld_after !== 3'b000 || rdy_after !== 3'b000 || rdy_after2 !== 3'b111)
      $display("FAIL bp_release: valid=%b ready=%b then ready=%b, want 000 000 111",
               vld_after, rdy_after, rdy_after2);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (dout(i) !== exp_v) $display("FAIL bp_ignored[%0d]: data=%h, want %h", i, dout(i), exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    valid = 1'b1;
    data  = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    valid = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (vld[i] !== 1'b0 || ordy[i] !== 1'b1 || dout(i) !== 128'h0)
        $display("FAIL reset_mid[%0d]: valid=%b ready=%b data=%h, want 0 1 0", i, vld[i], ordy[i], dout(i));
      else pass_cnt++;
    end
    cyc();
    rst = 1'b0;
    send({16{8'h63}});
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (lat_obs[i] !== LAT[i] || res_obs[i] !== 128'h0)
        $display("FAIL after_reset[%0d]: lat=%0d data=%h, want lat=%0d data=0",
                 i, lat_obs[i], res_obs[i], LAT[i]);
      else pass_cnt++;
    end
    release_out();
  endtask

  task automatic test_exhaustive();
    for (int t = 0; t < 256; t++) begin
      logic [127:0] din, exp_v;
      for (int k = 0; k < 16; k++) begin
        din[127 - 8*k -: 8]   = fwd[(t + k) & 255];
        exp_v[127 - 8*k -: 8] = 8'((t + k) & 255);
      end
      send(din);
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (lat_obs[i] !== LAT[i] || res_obs[i] !== exp_v)
          $display("FAIL exhaustive[t=%0d,%0d]: lat=%0d data=%h, want lat=%0d data=%h",
                   t, i, lat_obs[i], res_obs[i], LAT[i], exp_v);
        else pass_cnt++;
      end
      release_out();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [127:0] din = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] exp_v = model(din);
      send(din);
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (res_obs[i] !== exp_v)
          $display("FAIL random[%0d,%0d]: data=%h, want %h", n, i, res_obs[i], exp_v);
        else pass_cnt++;
      end
      release_out();
    end
  endtask

`ifdef AES_INV_SUB_BYTES_ABORT_EN
  task automatic test_abort_busy();
    logic seen = 1'b0;
    wait_ready();
    valid = 1'b1;
    data  = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    valid = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (vld !== 3'b000) seen = 1'b1;
      cyc();
    end
    total_cnt++;
    if (seen) $display("FAIL abort_busy: o_valid asserted after abort, want never");
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (dout(i) !== 128'h0 || ordy[i] !== 1'b1)
        $display("FAIL abort_clear[%0d]: data=%h ready=%b, want 0 1", i, dout(i), ordy[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort_idle();
    logic seen = 1'b0;
    wait_ready();
    abort = 1'b1;
    valid = 1'b1;
    data  = {4{32'hdeadbeef}};
    cyc();
    abort = 1'b0;
    valid = 1'b0;
    total_cnt++;
    if (ordy !== 3'b111) $display("FAIL abort_idle_ready: ready=%b, want 111", ordy);
    else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      if (vld !== 3'b000 || dout(0) !== 128'h0) seen = 1'b1;
      cyc();
    end
    total_cnt++;
    if (seen) $display("FAIL abort_idle_capture: state captured despite abort, want none");
    else pass_cnt++;
  endtask
`endif

  initial begin
    build_tables();
    test_reset();
    test_known();
    test_edge();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_exhaustive();
`ifdef AES_INV_SUB_BYTES_ABORT_EN
    test_abort_busy();
    test_abort_idle();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
